// File: rtl/bit_serial_alu.sv
// bit_serial_alu
//   LANES independent WIDTH-bit bit-serial ALUs sharing one opcode and one
//   control FSM. Operands are captured on an accepted start. One bit per clock
//   is then processed, LSB first. After WIDTH cycles the full result and the
//   per-lane carry are presented together with a single-cycle op_done pulse.
//
//   Optional feature macro: BIT_SERIAL_ALU_OVF_EN
//     When defined, adds the per-lane signed overflow output.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   start      operation request, sampled only while idle
//   op         00 ADD, 01 SUB (a-b), 10 XOR, 11 AND
//   a, b       operands, lane i at [i*WIDTH +: WIDTH]
//   busy       operation in progress
//   op_done    one-cycle pulse, result/carry_out valid
//   result     per-lane result, same packing as a
//   carry_out  per-lane final carry (1 = no borrow for SUB), 0 for XOR/AND
//   overflow   per-lane signed overflow (BIT_SERIAL_ALU_OVF_EN only)

module bit_serial_alu #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [LANES*WIDTH-1:0]   a,
  input  logic [LANES*WIDTH-1:0]   b,
  output logic                     busy,
  output logic                     op_done,
  output logic [LANES*WIDTH-1:0]   result,
  output logic [LANES-1:0]         carry_out
`ifdef BIT_SERIAL_ALU_OVF_EN
  ,
  output logic [LANES-1:0]         overflow
`endif
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  logic [0:0]             state;
  logic [IW-1:0]          idx;
  logic [1:0]             op_q;
  logic [LANES*WIDTH-1:0] a_q;
  logic [LANES*WIDTH-1:0] b_q;
  logic [LANES*WIDTH-1:0] acc;
  logic [LANES-1:0]       carry_q;

  logic [LANES-1:0]       s_bit;
  logic [LANES-1:0]       c_next;
  logic                   is_arith;
  logic                   b_inv;

  assign busy     = (state == RUN);
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign b_inv    = (op_q == OP_SUB);

  // The operand registers are shifted right each RUN cycle, so the current
  // bit of every lane always sits at the lane's LSB position.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    s_bit  = '0;
    c_next = '0;
    for (int i = 0; i < LANES; i++) begin
      if (is_arith) begin
        s_bit[i]  = a_q[i*WIDTH] ^ (b_q[i*WIDTH] ^ b_inv) ^ carry_q[i];
        c_next[i] = (a_q[i*WIDTH] & (b_q[i*WIDTH] ^ b_inv)) |
                    (a_q[i*WIDTH] & carry_q[i]) |
                    ((b_q[i*WIDTH] ^ b_inv) & carry_q[i]);
      end else if (op_q == OP_XOR) begin
        s_bit[i] = a_q[i*WIDTH] ^ b_q[i*WIDTH];
      end else begin
        s_bit[i] = a_q[i*WIDTH] & b_q[i*WIDTH];
      end
    end
  end

  // NOTE: all state, including the operand and accumulator registers, is
  // cleared by reset so a mid-operation abort leaves nothing stale behind.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      carry_q   <= '0;
      op_done   <= 1'b0;
      result    <= '0;
      carry_out <= '0;
`ifdef BIT_SERIAL_ALU_OVF_EN
      overflow  <= '0;
`endif
    end else begin
      op_done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= op;
          idx     <= '0;
          // SUB is a + ~b + 1: the +1 enters as the initial carry.
          carry_q <= {LANES{op == OP_SUB}};
          state   <= RUN;
        end
      end else begin
        for (int i = 0; i < LANES; i++) begin
          acc[i*WIDTH +: WIDTH] <= {s_bit[i], acc[i*WIDTH+1 +: WIDTH-1]};
          a_q[i*WIDTH +: WIDTH] <= a_q[i*WIDTH +: WIDTH] >> 1;
          b_q[i*WIDTH +: WIDTH] <= b_q[i*WIDTH +: WIDTH] >> 1;
        end
        carry_q <= c_next;
        if (idx == LAST_IDX) begin
          // The last bit is still in flight, so merge it into the result here.
          for (int i = 0; i < LANES; i++) begin
            result[i*WIDTH +: WIDTH] <= {s_bit[i], acc[i*WIDTH+1 +: WIDTH-1]};
          end
          carry_out <= c_next;
`ifdef BIT_SERIAL_ALU_OVF_EN
          // Carry into the MSB differs from carry out of it on signed overflow.
          // Both are 0 for XOR/AND, so overflow is 0 there too.
          overflow  <= carry_q ^ c_next;
`endif
          op_done   <= 1'b1;
          state     <= IDLE;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
module tb_bit_serial_alu;

  localparam int W = 16;
  localparam int L = 4;
  localparam int N = W * L;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [1:0]     op;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           op_done;
  logic [N-1:0]   result;
  logic [L-1:0]   carry_out;
`ifdef BIT_SERIAL_ALU_OVF_EN
  logic [L-1:0]   overflow;
`endif

  int checks = 0;
  int errors = 0;

  bit_serial_alu #(.WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .op_done   (op_done),
    .result    (result),
    .carry_out (carry_out)
`ifdef BIT_SERIAL_ALU_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: whole-word arithmetic per lane.
  function automatic void model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                input logic [1:0] opv, output logic [N-1:0] r,
                                output logic [L-1:0] c, output logic [L-1:0] v);
    logic [W-1:0] x, y;
    logic [W:0]   t;
    r = '0; c = '0; v = '0;
    for (int i = 0; i < L; i++) begin
      x = av[i*W +: W];
      y = bv[i*W +: W];
      case (opv)
        2'b00: t = {1'b0, x} + {1'b0, y};
        2'b01: t = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        2'b10: t = {1'b0, x ^ y};
        default: t = {1'b0, x & y};
      endcase
      r[i*W +: W] = t[W-1:0];
      c[i] = t[W];
      if (opv == 2'b00)
        v[i] = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
      else if (opv == 2'b01)
        v[i] = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    end
  endfunction

  function automatic logic [N-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  // Issues one operation and follows it to op_done (bounded). Returns at the
  // negedge on which op_done was seen (or after the budget expires).
  task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                       input logic [1:0] opv, output int busy_cycles,
                       output int done_cnt);
    @(negedge clk);
    a = av; b = bv; op = opv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = rand_vec(); b = rand_vec();
    busy_cycles = 0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy) busy_cycles++;
      if (op_done) begin
        done_cnt++;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b op_done=%b, expected 0 0", busy, op_done);
    end
    checks++;
    if (result !== '0 || carry_out !== '0) begin
      errors++;
      $display("FAIL reset_data: result=%h carry=%b, expected 0", result, carry_out);
    end
`ifdef BIT_SERIAL_ALU_OVF_EN
    checks++;
    if (overflow !== '0) begin
      errors++;
      $display("FAIL reset_ovf: overflow=%b, expected 0", overflow);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [N-1:0] av, bv, er;
    logic [L-1:0] ec, ev;
    int bc, dc;
    av = rand_vec(); bv = rand_vec();
    av[15:0] = 16'hFFFF; bv[15:0] = 16'h0001;
    av[31:16] = 16'h1234; bv[31:16] = 16'h4321;
    model(av, bv, 2'b00, er, ec, ev);
    do_op(av, bv, 2'b00, bc, dc);
    checks++;
    if (dc !== 1 || bc !== W) begin
      errors++;
      $display("FAIL add_timing: done=%0d busy_cycles=%0d, expected 1 %0d", dc, bc, W);
    end
    checks++;
    if (result[31:0] !== 32'h5555_0000 || carry_out[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL add_directed: result=%h carry=%b, expected 55550000 01",
               result[31:0], carry_out[1:0]);
    end
    checks++;
    if (result !== er || carry_out !== ec) begin
      errors++;
      $display("FAIL add_model: result=%h carry=%b, expected %h %b", result, carry_out, er, ec);
    end
    @(negedge clk);
    checks++;
    if (op_done !== 1'b0 || result !== er) begin
      errors++;
      $display("FAIL add_hold: op_done=%b result=%h, expected 0 %h", op_done, result, er);
    end
  endtask

  task automatic test_sub_logic();
    logic [N-1:0] av, bv, er;
    logic [L-1:0] ec, ev;
    int bc, dc;
    av = {16'h0000, 16'hFFFF, 16'h0007, 16'h0005};
    bv = {16'h0000, 16'h0001, 16'h0005, 16'h0007};
    model(av, bv, 2'b01, er, ec, ev);
    do_op(av, bv, 2'b01, bc, dc);
    checks++;
    if (dc !== 1 || result[31:0] !== 32'h0002_FFFE || carry_out[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL sub_directed: done=%0d result=%h carry=%b, expected 1 0002fffe 10",
               dc, result[31:0], carry_out[1:0]);
    end
    checks++;
    if (result !== er || carry_out !== ec) begin
      errors++;
      $display("FAIL sub_model: result=%h carry=%b, expected %h %b", result, carry_out, er, ec);
    end
    av = {4{16'hF0F0}}; bv = {4{16'hFF00}};
    do_op(av, bv, 2'b10, bc, dc);
    checks++;
    if (dc !== 1 || result !== {4{16'h0FF0}} || carry_out !== '0) begin
      errors++;
      $display("FAIL xor_directed: done=%0d result=%h carry=%b, expected 1 0ff0x4 0",
               dc, result, carry_out);
    end
    do_op(av, bv, 2'b11, bc, dc);
    checks++;
    if (dc !== 1 || result !== {4{16'hF000}} || carry_out !== '0) begin
      errors++;
      $display("FAIL and_directed: done=%0d result=%h carry=%b, expected 1 f000x4 0",
               dc, result, carry_out);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] av, bv, er;
    logic [L-1:0] ec, ev;
    logic [1:0]   opv;
    int bc, dc;
    for (int t = 0; t < 24; t++) begin
      av = rand_vec(); bv = rand_vec();
      opv = 2'($urandom_range(0, 3));
      model(av, bv, opv, er, ec, ev);
      do_op(av, bv, opv, bc, dc);
      checks++;
      if (dc !== 1 || bc !== W || result !== er || carry_out !== ec) begin
        errors++;
        $display("FAIL random[%0d] op=%0d: done=%0d busy=%0d result=%h carry=%b, expected 1 %0d %h %b",
                 t, opv, dc, bc, result, carry_out, W, er, ec);
      end
`ifdef BIT_SERIAL_ALU_OVF_EN
      checks++;
      if (overflow !== ev) begin
        errors++;
        $display("FAIL random_ovf[%0d]: overflow=%b, expected %b", t, overflow, ev);
      end
`endif
    end
  endtask

  task automatic test_midrun_changes();
    logic [N-1:0] av, bv, er;
    logic [L-1:0] ec, ev;
    int dc;
    av = rand_vec(); bv = rand_vec();
    model(av, bv, 2'b01, er, ec, ev);
    @(negedge clk);
    a = av; b = bv; op = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    for (int n = 0; n < 40; n++) begin
      start = (n == 3 || n == 8);
      a = rand_vec(); b = rand_vec(); op = 2'($urandom_range(0, 3));
      if (op_done) dc++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (dc !== 1) begin
      errors++;
      $display("FAIL midrun_done_count: got %0d, expected 1", dc);
    end
    checks++;
    if (result !== er || carry_out !== ec) begin
      errors++;
      $display("FAIL midrun_result: result=%h carry=%b, expected %h %b", result, carry_out, er, ec);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] av1, bv1, av2, bv2, er1, er2;
    logic [L-1:0] ec1, ec2, ev;
    int bc;
    bit seen;
    av1 = rand_vec(); bv1 = rand_vec();
    av2 = rand_vec(); bv2 = rand_vec();
    model(av1, bv1, 2'b00, er1, ec1, ev);
    model(av2, bv2, 2'b01, er2, ec2, ev);
    @(negedge clk);
    a = av1; b = bv1; op = 2'b00; start = 1'b1;
    @(negedge clk);
    a = rand_vec(); b = rand_vec(); op = 2'b11;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (op_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen || result !== er1 || carry_out !== ec1) begin
      errors++;
      $display("FAIL b2b_first: seen=%b result=%h carry=%b, expected 1 %h %b",
               seen, result, carry_out, er1, ec1);
    end
    a = av2; b = bv2; op = 2'b01;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || op_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b op_done=%b, expected 1 0", busy, op_done);
    end
    start = 1'b0;
    a = rand_vec(); b = rand_vec();
    bc = 0;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (busy) bc++;
      if (op_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen || bc !== W || result !== er2 || carry_out !== ec2) begin
      errors++;
      $display("FAIL b2b_second: seen=%b busy=%0d result=%h carry=%b, expected 1 %0d %h %b",
               seen, bc, result, carry_out, W, er2, ec2);
    end
  endtask

  task automatic test_reset_midrun();
    logic [N-1:0] av, bv, er;
    logic [L-1:0] ec, ev;
    int bc, dc;
    @(negedge clk);
    a = rand_vec(); b = rand_vec(); op = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || op_done !== 1'b0 || result !== '0 || carry_out !== '0) begin
      errors++;
      $display("FAIL rst_midrun: busy=%b op_done=%b result=%h carry=%b, expected all 0",
               busy, op_done, result, carry_out);
    end
`ifdef BIT_SERIAL_ALU_OVF_EN
    checks++;
    if (overflow !== '0) begin
      errors++;
      $display("FAIL rst_midrun_ovf: overflow=%b, expected 0", overflow);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    dc = 0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (op_done || busy) dc++;
    end
    checks++;
    if (dc !== 0) begin
      errors++;
      $display("FAIL rst_no_done: activity cycles=%0d, expected 0", dc);
    end
    av = rand_vec(); bv = rand_vec();
    model(av, bv, 2'b00, er, ec, ev);
    do_op(av, bv, 2'b00, bc, dc);
    checks++;
    if (dc !== 1 || bc !== W || result !== er || carry_out !== ec) begin
      errors++;
      $display("FAIL rst_fresh_add: done=%0d busy=%0d result=%h carry=%b, expected 1 %0d %h %b",
               dc, bc, result, carry_out, W, er, ec);
    end
  endtask

`ifdef BIT_SERIAL_ALU_OVF_EN
  task automatic test_overflow();
    int bc, dc;
    do_op({4{16'h7FFF}}, {4{16'h0001}}, 2'b00, bc, dc);
    checks++;
    if (dc !== 1 || result !== {4{16'h8000}} || overflow !== 4'hF || carry_out !== 4'h0) begin
      errors++;
      $display("FAIL ovf_add: result=%h ovf=%b carry=%b, expected 8000x4 1111 0000",
               result, overflow, carry_out);
    end
    do_op({4{16'h8000}}, {4{16'h0001}}, 2'b01, bc, dc);
    checks++;
    if (dc !== 1 || result !== {4{16'h7FFF}} || overflow !== 4'hF || carry_out !== 4'hF) begin
      errors++;
      $display("FAIL ovf_sub: result=%h ovf=%b carry=%b, expected 7fffx4 1111 1111",
               result, overflow, carry_out);
    end
    do_op({4{16'h7FFF}}, {4{16'h7FFF}}, 2'b10, bc, dc);
    checks++;
    if (dc !== 1 || overflow !== 4'h0) begin
      errors++;
      $display("FAIL ovf_logic: ovf=%b, expected 0000", overflow);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub_logic();
    test_random();
    test_midrun_changes();
    test_back_to_back();
    test_reset_midrun();
`ifdef BIT_SERIAL_ALU_OVF_EN
    test_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
